taxi_i2c_slave_regfile: RTL and testbench

- Byte-wide register file sitting directly downstream/upstream of the I2C slave.
- Consumes the slave's received-byte AXI stream: first byte of each write = register pointer, following bytes = data with pointer auto-increment.
- Supplies the slave's transmit AXI stream with register contents on I2C reads, auto-incrementing.
- Fabric-side host port gives direct register read/write access.

---
 rtl/taxi_i2c_slave_regfile.sv | 188 ++++++++++++++++++
 tb/tb_taxi_i2c_slave_regfile.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_i2c_slave_regfile.sv
// taxi_i2c_slave_regfile
// Byte-wide register file between an I2C slave's AXI streams and a fabric host.
// The first RX byte of each I2C write loads the register pointer; the following
// bytes are stored with pointer auto-increment. TX bytes are fetched from the
// pointer on demand, also auto-incrementing.
// Optional feature macro: TAXI_I2C_REGFILE_WRAP_EN
//   defined   : pointer increments modulo 2**ADDR_W
//   undefined : pointer saturates at the last address and an end flag blocks
//               further I2C writes and makes reads return 0xFF until the next
//               pointer load
//
// TX state | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no byte pending; waits for the consumer to request one
// FETCH    | samples mem[ptr] into the output data register
// VALID    | byte presented; waits for the handshake, then advances ptr
module taxi_i2c_slave_regfile #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        i_s_axis_rx_tdata,
  input  logic              i_s_axis_rx_tvalid,
  output logic              o_s_axis_rx_tready,
  input  logic              i_s_axis_rx_tlast,
  output logic [7:0]        o_m_axis_tx_tdata,
  output logic              o_m_axis_tx_tvalid,
  input  logic              i_m_axis_tx_tready,
  output logic              o_m_axis_tx_tlast,
  output logic              o_m_axis_tx_tkeep,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic              i_host_wr_en,
  input  logic [7:0]        i_host_wr_data,
  output logic [7:0]        o_host_rd_data,
  output logic              o_i2c_wr_valid,
  output logic [ADDR_W-1:0] o_i2c_wr_addr,
  output logic [7:0]        o_i2c_wr_data,
  output logic [ADDR_W-1:0] o_ptr
);

  localparam int                DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_VALID} tx_state_t;

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_ptr;
  logic              r_first;
  logic              r_rx_ready;
  tx_state_t         r_state;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;
  logic [7:0]        r_rd_data;
  logic              r_wr_valid;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;

  logic              w_rx_beat;
  logic              w_rx_load;
  logic              w_rx_data;
  logic              w_rx_write;
  logic              w_tx_hs;
  logic [1:0]        w_inc_cnt;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic [7:0]        w_fetch_data;

  assign w_rx_beat = i_s_axis_rx_tvalid & r_rx_ready;
  assign w_rx_load = w_rx_beat & r_first;
  assign w_rx_data = w_rx_beat & ~r_first;
  assign w_tx_hs   = r_tx_valid & i_m_axis_tx_tready;

`ifdef TAXI_I2C_REGFILE_WRAP_EN
  assign w_rx_write   = w_rx_data;
  assign w_inc_cnt    = {1'b0, w_rx_write} + {1'b0, w_tx_hs};
  assign w_ptr_nxt    = r_ptr + ADDR_W'(w_inc_cnt);
  assign w_fetch_data = r_mem[r_ptr];
`else
  logic              r_end;
  logic [ADDR_W+1:0] w_ptr_sum;
  logic              w_end_set;

  // Once the last address has been touched, I2C writes are dropped.
  assign w_rx_write   = w_rx_data & ~r_end;
  assign w_inc_cnt    = {1'b0, w_rx_write} + {1'b0, w_tx_hs};
  assign w_ptr_sum    = {2'b00, r_ptr} + {{ADDR_W{1'b0}}, w_inc_cnt};
  assign w_ptr_nxt    = (w_ptr_sum > {2'b00, LAST}) ? LAST : w_ptr_sum[ADDR_W-1:0];
  assign w_end_set    = (w_rx_write | w_tx_hs) & (r_ptr == LAST);
  assign w_fetch_data = r_end ? 8'hFF : r_mem[r_ptr];

  // End flag: set by an access at the last address, cleared by a pointer load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_end <= 1'b0;
    end else if (w_rx_load) begin
      r_end <= 1'b0;
    end else if (w_end_set) begin
      r_end <= 1'b1;
    end
  end
`endif

  // Register array; the host write is applied last so it wins an address tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else begin
      if (w_rx_write)   r_mem[r_ptr]       <= i_s_axis_rx_tdata;
      if (i_host_wr_en) r_mem[i_host_addr] <= i_host_wr_data;
    end
  end

  // Pointer and first-byte tracking; a pointer load overrides any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_first    <= 1'b1;
      r_rx_ready <= 1'b0;
    end else begin
      r_rx_ready <= 1'b1;
      if (w_rx_beat) r_first <= i_s_axis_rx_tlast;
      if (w_rx_load) r_ptr <= i_s_axis_rx_tdata[ADDR_W-1:0];
      else           r_ptr <= w_ptr_nxt;
    end
  end

  // Notification pulse for each stored I2C data byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 8'h00;
    end else begin
      r_wr_valid <= w_rx_write;
      if (w_rx_write) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= i_s_axis_rx_tdata;
      end
    end
  end

  // Host read port, one cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_data <= 8'h00;
    else        r_rd_data <= r_mem[i_host_addr];
  end

  // TX fetch state machine; data is captured in FETCH and held until handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_m_axis_tx_tready && !r_tx_valid) r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          r_tx_data  <= w_fetch_data;
          r_tx_valid <= 1'b1;
          r_state    <= ST_VALID;
        end
        ST_VALID: begin
          if (i_m_axis_tx_tready) begin
            r_tx_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_s_axis_rx_tready = r_rx_ready;
  assign o_m_axis_tx_tdata  = r_tx_data;
  assign o_m_axis_tx_tvalid = r_tx_valid;
  assign o_m_axis_tx_tlast  = 1'b0;
  assign o_m_axis_tx_tkeep  = 1'b1;
  assign o_host_rd_data     = r_rd_data;
  assign o_i2c_wr_valid     = r_wr_valid;
  assign o_i2c_wr_addr      = r_wr_addr;
  assign o_i2c_wr_data      = r_wr_data;
  assign o_ptr              = r_ptr;

endmodule

// File: tb/tb_taxi_i2c_slave_regfile.sv
// Directed bench for taxi_i2c_slave_regfile (ADDR_W = 4).
module tb_taxi_i2c_slave_regfile;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_tdata = 8'h00;
  logic       rx_tvalid = 1'b0;
  logic       rx_tready;
  logic       rx_tlast = 1'b0;
  logic [7:0] tx_tdata;
  logic       tx_tvalid;
  logic       tx_tready = 1'b0;
  logic       tx_tlast;
  logic       tx_tkeep;
  logic [3:0] host_addr = 4'h0;
  logic       host_wr_en = 1'b0;
  logic [7:0] host_wr_data = 8'h00;
  logic [7:0] host_rd_data;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] ptr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] q_addr[$];
  logic [7:0] q_data[$];

  always #5 clk = ~clk;

  taxi_i2c_slave_regfile #(.ADDR_W(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_s_axis_rx_tdata  (rx_tdata),
    .i_s_axis_rx_tvalid (rx_tvalid),
    .o_s_axis_rx_tready (rx_tready),
    .i_s_axis_rx_tlast  (rx_tlast),
    .o_m_axis_tx_tdata  (tx_tdata),
    .o_m_axis_tx_tvalid (tx_tvalid),
    .i_m_axis_tx_tready (tx_tready),
    .o_m_axis_tx_tlast  (tx_tlast),
    .o_m_axis_tx_tkeep  (tx_tkeep),
    .i_host_addr        (host_addr),
    .i_host_wr_en       (host_wr_en),
    .i_host_wr_data     (host_wr_data),
    .o_host_rd_data     (host_rd_data),
    .o_i2c_wr_valid     (wr_valid),
    .o_i2c_wr_addr      (wr_addr),
    .o_i2c_wr_data      (wr_data),
    .o_ptr              (ptr)
  );

  // Record every write-notification pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_valid) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rx_beat(input logic [7:0] d, input logic last);
    @(posedge clk); #1;
    rx_tvalid = 1'b1; rx_tdata = d; rx_tlast = last;
    @(posedge clk); #1;
    rx_tvalid = 1'b0; rx_tlast = 1'b0;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    host_addr = a; host_wr_en = 1'b1; host_wr_data = d;
    @(posedge clk); #1;
    host_wr_en = 1'b0;
  endtask

  task automatic host_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
    @(posedge clk); #1;
    host_addr = a;
    @(posedge clk); #1;
    check(tag, host_rd_data, exp);
  endtask

  // Raise tready, count cycles until tvalid, then drop tready so the byte is held.
  task automatic tx_wait_valid(output int lat);
    @(posedge clk); #1;
    tx_tready = 1'b1;
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      lat++;
      if (tx_tvalid) break;
    end
    tx_tready = 1'b0;
  endtask

  task automatic tx_finish();
    @(posedge clk); #1;
    tx_tready = 1'b1;
    @(posedge clk); #1;
    tx_tready = 1'b0;
  endtask

  initial begin
    int lat;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    // Reset values
    #23 rst_n = 1'b1;
    check("rst_ptr", ptr, 4'h0);
    check("rst_tvalid", tx_tvalid, 1'b0);
    check("rst_tdata", tx_tdata, 8'h00);
    check("rst_wr_valid", wr_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rx_tready", rx_tready, 1'b1);
    for (int i = 0; i < 16; i++) host_check($sformatf("rst_mem%0d", i), 4'(i), 8'h00);

    // Write burst
    q_addr.delete(); q_data.delete();
    rx_beat(8'h03, 1'b0);
    check("ptr_load3", ptr, 4'h3);
    rx_beat(8'hA1, 1'b0);
    rx_beat(8'hB2, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("burst_ptr", ptr, 4'h5);
    check("burst_pulses", q_addr.size(), 2);
    if (q_addr.size() >= 2) begin
      check("burst_p0_addr", q_addr[0], 4'h3);
      check("burst_p0_data", q_data[0], 8'hA1);
      check("burst_p1_addr", q_addr[1], 4'h4);
      check("burst_p1_data", q_data[1], 8'hB2);
    end
    host_check("mem3", 4'h3, 8'hA1);
    host_check("mem4", 4'h4, 8'hB2);

    // Repeated-start read of 2 bytes from address 4
    host_write(4'h5, 8'h5C);
    rx_beat(8'h04, 1'b1);
    check("ptr_load4", ptr, 4'h4);
    tx_wait_valid(lat);
    check("rd0_latency", lat, 2);
    check("rd0_data", tx_tdata, 8'hB2);
    check("rd0_tlast", tx_tlast, 1'b0);
    check("rd0_tkeep", tx_tkeep, 1'b1);
    tx_finish();
    check("rd0_tvalid_low", tx_tvalid, 1'b0);
    check("rd0_ptr", ptr, 4'h5);
    tx_wait_valid(lat);
    check("rd1_latency", lat, 2);
    check("rd1_data", tx_tdata, 8'h5C);
    tx_finish();
    check("rd1_ptr", ptr, 4'h6);

    // Host and I2C write to address 7 in the same cycle
    q_addr.delete(); q_data.delete();
    rx_beat(8'h07, 1'b0);
    @(posedge clk); #1;
    rx_tvalid = 1'b1; rx_tdata = 8'h66; rx_tlast = 1'b1;
    host_addr = 4'h7; host_wr_en = 1'b1; host_wr_data = 8'h55;
    @(posedge clk); #1;
    rx_tvalid = 1'b0; rx_tlast = 1'b0; host_wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("coll_pulses", q_addr.size(), 1);
    if (q_addr.size() >= 1) begin
      check("coll_p_addr", q_addr[0], 4'h7);
      check("coll_p_data", q_data[0], 8'h66);
    end
    host_check("coll_mem7", 4'h7, 8'h55);
    check("coll_ptr", ptr, 4'h8);

    // TX data is frozen once fetched
    host_write(4'h8, 8'h12);
    tx_wait_valid(lat);
    check("frz_data0", tx_tdata, 8'h12);
    host_write(4'h8, 8'h34);
    check("frz_data1", tx_tdata, 8'h12);
    tx_finish();
    host_check("frz_mem8", 4'h8, 8'h34);
    check("frz_ptr", ptr, 4'h9);

    // Boundary at the last address
    q_addr.delete(); q_data.delete();
    rx_beat(8'h0F, 1'b0);
    rx_beat(8'h11, 1'b0);
    rx_beat(8'h22, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    host_check("bnd_mem15", 4'hF, 8'h11);
`ifdef TAXI_I2C_REGFILE_WRAP_EN
    check("bnd_pulses", q_addr.size(), 2);
    check("bnd_ptr", ptr, 4'h1);
    host_check("bnd_mem0", 4'h0, 8'h22);
    tx_wait_valid(lat);
    check("bnd_rd", tx_tdata, 8'h00);
    tx_finish();
    check("bnd_rd_ptr", ptr, 4'h2);
`else
    check("bnd_pulses", q_addr.size(), 1);
    check("bnd_ptr", ptr, 4'hF);
    host_check("bnd_mem0", 4'h0, 8'h00);
    tx_wait_valid(lat);
    check("bnd_rd", tx_tdata, 8'hFF);
    tx_finish();
    check("bnd_rd_ptr", ptr, 4'hF);
`endif

    // Async reset while a byte is presented
    rx_beat(8'h02, 1'b1);
    tx_wait_valid(lat);
    check("arst_pre_tvalid", tx_tvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tvalid", tx_tvalid, 1'b0);
    check("arst_ptr", ptr, 4'h0);
    #10 rst_n = 1'b1;
    host_check("arst_mem3", 4'h3, 8'h00);
    host_check("arst_mem7", 4'h7, 8'h00);
    host_check("arst_mem15", 4'hF, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("arst_idle_tvalid", tx_tvalid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
